// File: rtl/req_frame_tx.sv
// req_frame_tx: 8N1 UART sender of one 4-byte request frame (header, b1, b2, xor) per send_req level.
module req_frame_tx #(
  parameter int         CLK_FREQ = 25_000_000,
  parameter int         BAUD     = 115_200,
  parameter logic [7:0] HEADER   = 8'hAA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_req,
  input  logic [7:0] byte1,
  input  logic [7:0] byte2,
  output logic       tx,
  output logic       busy,
  output logic       tx_done_pulse
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  if (DIV < 2) begin : g_bad_div
    $error("req_frame_tx: CLK_FREQ/BAUD must be at least 2");
  end
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
  state_t          state, state_n;
  logic            armed;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n;
  logic [1:0]      byte_idx, byte_n;
  logic [31:0]     frame;
  logic            tick, tx_n, done_n;
  assign tick = cnt == CW'(DIV - 1);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    case (state)
      IDLE:  if (send_req && armed) state_n = LOAD;
      LOAD:  begin
        state_n = START;
        byte_n  = '0;
      end
      START: if (tick) begin
        state_n = DATA;
        bit_n   = '0;
      end
      DATA:  if (tick) begin
        bit_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = STOP;
      end
      STOP:  if (tick) begin
        state_n = (byte_idx == 2'd3) ? IDLE : START;
        byte_n  = byte_idx + 2'd1;
      end
      default: state_n = IDLE;
    endcase
    cnt_n  = (state_n != state || tick || state == IDLE) ? '0 : cnt + 1'b1;
    // line level is registered from the next state so it changes exactly on state entry
    tx_n   = (state_n == START) ? 1'b0 : (state_n == DATA) ? frame[{byte_n, bit_n}] : 1'b1;
    done_n = state == STOP && tick && byte_idx == 2'd3;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      armed         <= 1'b0;
      cnt           <= '0;
      bit_idx       <= '0;
      byte_idx      <= '0;
      frame         <= '0;
      tx            <= 1'b1;
      tx_done_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bit_idx       <= bit_n;
      byte_idx      <= byte_n;
      tx            <= tx_n;
      tx_done_pulse <= done_n;
      if (state == IDLE) armed <= !send_req;
      if (state == LOAD) frame <= {HEADER ^ byte1 ^ byte2, byte2, byte1, HEADER};
    end
  end
endmodule

// File: tb/tb_req_frame_tx.sv
// tb_req_frame_tx: table-driven frames with a UART-decoding scoreboard, plus re-arm and reset sequences.
module tb_req_frame_tx;
  localparam int DIV = 10;
  logic clk = 1'b0, rst, send_req, tx, busy, tx_done_pulse;
  logic [7:0] byte1, byte2;
  int checks = 0, failures = 0, epoch = 0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] b1, b2, e1, c;
    int         drop_at;
  } vec_t;
  vec_t vecs[12];

  req_frame_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .HEADER(8'hAA)) dut (
    .clk(clk), .rst(rst), .send_req(send_req), .byte1(byte1), .byte2(byte2),
    .tx(tx), .busy(busy), .tx_done_pulse(tx_done_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always begin : mon
    logic [7:0] d;
    int ep;
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      ep = epoch;
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        d[i] = tx;
      end
      repeat (DIV) @(negedge clk);
      if (ep == epoch) begin
        chk("stop_bit", {31'b0, tx}, 1);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h expected no byte", d);
        end else chk("line_byte", {24'b0, d}, {24'b0, q.pop_front()});
      end
    end
  end

  task automatic do_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] e1,
                          input logic [7:0] c, input int drop_at);
    int n = 0;
    bit busy_ok = 1'b1;
    byte1 = b1;
    byte2 = b2;
    q.push_back(8'hAA); q.push_back(e1); q.push_back(b2); q.push_back(c);
    send_req = 1'b1;
    @(posedge clk); #1;
    chk("busy_in_load", {31'b0, busy}, 1);
    chk("tx_in_load", {31'b0, tx}, 1);
    byte1 = e1;
    while (!tx_done_pulse && n < 500) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("tx_start_fall", {31'b0, tx}, 0);
      if (n == 150) begin
        byte1 = 8'hFF;
        byte2 = 8'h5C;
      end
      if (n == drop_at) send_req = 1'b0;
    end
    chk("busy_during_frame", {31'b0, busy_ok}, 1);
    chk("done_latency", n, 401);
    chk("busy_at_done", {31'b0, busy}, 0);
    chk("tx_at_done", {31'b0, tx}, 1);
    @(posedge clk); #1;
    chk("done_width", {31'b0, tx_done_pulse}, 0);
    chk("tx_idle_after", {31'b0, tx}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    vecs[0]  = '{8'h09, 8'h00, 8'h09, 8'hA3, -1};
    vecs[1]  = '{8'h00, 8'h00, 8'h06, 8'hAC, -1};
    vecs[2]  = '{8'h05, 8'h0A, 8'h05, 8'hA5, 200};
    vecs[3]  = '{8'h05, 8'h05, 8'h05, 8'hAA, -1};
    vecs[4]  = '{8'h05, 8'h0A, 8'h05, 8'hA5, -1};
    vecs[5]  = '{8'h05, 8'hFF, 8'h05, 8'h50, -1};
    vecs[6]  = '{8'h0A, 8'h05, 8'h0A, 8'hA5, -1};
    vecs[7]  = '{8'h0A, 8'h0A, 8'h0A, 8'hAA, -1};
    vecs[8]  = '{8'h0A, 8'hFF, 8'h0A, 8'h5F, -1};
    vecs[9]  = '{8'hFF, 8'h05, 8'hFF, 8'h50, -1};
    vecs[10] = '{8'hFF, 8'h0A, 8'hFF, 8'h5F, -1};
    vecs[11] = '{8'hFF, 8'hFF, 8'hFF, 8'hAA, -1};
    rst = 1'b1;
    send_req = 1'b0;
    byte1 = '0;
    byte2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", {31'b0, tx}, 1);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, tx_done_pulse}, 0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 12; i++) begin
      do_frame(vecs[i].b1, vecs[i].b2, vecs[i].e1, vecs[i].c, vecs[i].drop_at);
      send_req = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
    end
    // request held high after done must not start another frame
    do_frame(8'h33, 8'h44, 8'h33, 8'hDD, -1);
    quiet = 1'b1;
    repeat (1000) begin
      @(posedge clk); #1;
      if (busy || !tx || tx_done_pulse) quiet = 1'b0;
    end
    chk("held_req_quiet", {31'b0, quiet}, 1);
    send_req = 1'b0;
    @(posedge clk); #1;
    do_frame(8'h12, 8'h34, 8'h12, 8'h8C, -1);
    send_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    // reset during a zero data bit of byte 1
    byte1 = 8'h00;
    byte2 = 8'h00;
    q.push_back(8'hAA); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'hAA);
    send_req = 1'b1;
    @(posedge clk); #1;
    repeat (130) @(posedge clk);
    #1;
    chk("tx_low_before_rst", {31'b0, tx}, 0);
    epoch++;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", {31'b0, tx}, 1);
    chk("async_rst_busy", {31'b0, busy}, 0);
    q.delete();
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (tx_done_pulse || busy || !tx) quiet = 1'b0;
    end
    rst = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (tx_done_pulse || busy || !tx) quiet = 1'b0;
    end
    chk("post_rst_quiet", {31'b0, quiet}, 1);
    send_req = 1'b0;
    @(posedge clk); #1;
    do_frame(8'h01, 8'h02, 8'h01, 8'hA9, -1);
    send_req = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/req_frame_tx.md
# req_frame_tx

UART transmitter for menu request frames, sitting directly downstream of the menu state machine. While its request input is high, it captures the two request bytes and serializes a 4-byte frame over an 8N1 line: header, byte1, byte2, XOR checksum. It then returns the one-cycle `tx_done_pulse` that lets the menu leave its send state. It re-arms only after the request drops, so exactly one frame is sent per request.

## Interface
- `CLK_FREQ`, default 25_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate.
  - `DIV = CLK_FREQ / BAUD`, integer-truncated; 217 at defaults.
  - `DIV < 2` is an elaboration error.
- `HEADER`, default 8'hAA: first byte of every frame.

Ports:
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset; asynchronous, active-high.
- `send_req  in  1`: level request; high while the menu sits in its send state.
- `byte1  in  8`: request byte `{4'b0, sensor, sala}`.
- `byte2  in  8`: payload byte.
- `tx  out  1`: serial line; idles high.
- `busy  out  1`: high from LOAD through the last stop bit.
- `tx_done_pulse  out  1`: one-cycle pulse at frame end.

## Operation
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - `tx=1`.
  - If `send_req` is low, set `armed<=1`.
  - If `send_req && armed`, go to LOAD and clear `armed`.
- LOAD, one cycle:
  - Capture `byte1` and `byte2`. Inputs are sampled here, one cycle after the request, because upstream registers its bytes one cycle after entering the send state.
  - Build the frame `{HEADER, b1, b2, HEADER^b1^b2}`.
  - Set `byte_idx=0` and go to START.
- START: `tx=0` for DIV cycles, then DATA with `bit_idx=0`.
- DATA:
  - `tx=` current byte bit `bit_idx`, LSB first, DIV cycles per bit.
  - After bit 7, go to STOP.
- STOP:
  - `tx=1` for DIV cycles.
  - If `byte_idx<3`: increment it and go to START. Stop bit is directly followed by the next start bit; there is no inter-byte gap.
  - Otherwise pulse `tx_done_pulse` and go to IDLE.
- Baud counter:
  - Counts 0..DIV-1 and is cleared on every state entry.
  - Width is `$clog2(DIV)` bits.
- Captured bytes are immune to input changes after LOAD.
- A `send_req` drop mid-frame does not abort the frame; the frame completes and `tx_done_pulse` still fires.
- `send_req` still high after done: no new frame until it has been low for at least one cycle in IDLE.
- Reset values:
  - `tx=1`, `busy=0`, `tx_done_pulse=0`.
  - State IDLE, `armed=0`, all counters 0.
- Reset mid-frame: `tx` returns high asynchronously and the partial frame is dropped with no done pulse. A request already high at reset release is ignored until it goes low.
- `tx` is driven from a register; there are no combinational glitches on the line.

## Timing
- Edge N samples `send_req=1` with `armed=1` in IDLE, so LOAD is active after edge N.
- Edge N+1: START entered; `tx` falls after this edge; `busy` is high from after edge N.
- Bit k of byte j, counting the start bit as bit 0 and the stop bit as bit 9, occupies cycles `[N+1 + (10j+k)·DIV, +DIV)`.
- `tx_done_pulse` is high for exactly one cycle after edge `N+1+40·DIV`.
  - `busy` falls on the same edge.
  - `tx` remains high.
- Earliest next LOAD: two cycles after the done pulse, since one low cycle of `send_req` is required first.
- Total request-to-done latency: `40·DIV+1` cycles.

## Test plan
All scenarios use `CLK_FREQ=1_000_000`, `BAUD=100_000`, so `DIV=10`.

1. **Basic frame.**
   - Stimulus: hold `byte1=0x09`, `byte2=0x00`; raise `send_req`.
   - Required: line decodes AA 09 00 A3, LSB first; `tx` falls one cycle after LOAD; `tx_done_pulse` is a single cycle exactly 401 cycles after the request edge; `busy` is high throughout.
2. **Late-valid bytes.**
   - Stimulus: raise `send_req` with `byte1=0x00`; change to `0x06` one cycle later, then to `0xFF` mid-frame.
   - Required: frame AA 06 00 AC.
3. **Re-arm.**
   - Stimulus: hold `send_req` high for 1000 cycles after done.
   - Required: exactly one frame sent.
   - Stimulus: drop `send_req` for 1 cycle, then raise it again.
   - Required: second frame starts, with LOAD 1 cycle after the rise.
4. **Request drop mid-frame.**
   - Stimulus: `send_req` falls at byte 2.
   - Required: all 4 bytes are sent and `tx_done_pulse` still fires.
5. **Reset mid-frame.**
   - Stimulus: assert `rst` during a DATA bit of byte 1.
   - Required: `tx=1` asynchronously, `busy=0`, no done pulse; no new frame while `send_req` stays high after release; a frame follows a low-then-high request.
6. **Checksum sweep.**
   - Stimulus: `byte1`/`byte2` = {0x05, 0x0A, 0xFF}².
   - Required: checksum always equals `0xAA^b1^b2`; line idle-high between frames.
